// File: rtl/clz_share_arb.sv
// rtl/clz_share_arb.sv - round-robin arbiter sharing one clz64 counter among N_REQ requesters
// Two-stage pipeline: S0 holds the granted word, S1 holds the tagged leading-zero result.

module clz64 (
   input  logic [63:0] a,
   output logic [5:0]  y
);
   // Leading zeros inside one byte; only meaningful when the byte is nonzero.
   function automatic logic [2:0] byte_lz(input logic [7:0] v);
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) r = 3'(7 - i);
      end
      return r;
   endfunction

   logic [7:0]      nz;
   logic [7:0][2:0] lz;
   logic            found;

   for (genvar g = 0; g < 8; g++) begin : g_byte
      assign nz[g] = |a[8*g +: 8];
      assign lz[g] = byte_lz(a[8*g +: 8]);
   end

   // Most significant nonzero byte selects the upper three bits; all-zero input yields 0.
   always_comb begin
      y     = '0;
      found = 1'b0;
      for (int b = 7; b >= 0; b--) begin
         if (!found && nz[b]) begin
            found = 1'b1;
            y     = {3'(7 - b), lz[b]};
         end
      end
   end
endmodule

module clz_share_arb #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [64*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ID_W-1:0]       out_id,
   output logic [6:0]            out_clz,
   output logic                  out_zero,
   output logic [15:0]           res_count
);
   localparam logic [ID_W:0] N_REQ_W = (ID_W + 1)'(N_REQ);

   logic [ID_W-1:0]  last;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_id;
   logic             found;
   logic [ID_W:0]    sum;
   logic [ID_W-1:0]  idx;
   logic [63:0]      sel_data;
   logic             xfer;

   logic             s0_valid;
   logic [ID_W-1:0]  s0_id;
   logic [63:0]      s0_data;
   logic             s1_valid;
   logic [ID_W-1:0]  s1_id;
   logic [6:0]       s1_clz;
   logic             s1_zero;
   logic             s0_en;
   logic             s1_en;
   logic [5:0]       clz_y;

   assign s1_en = !s1_valid | out_ready;
   assign s0_en = !s0_valid | s1_en;

   // Search last+1, last+2, ... wrapping at N_REQ; sum never exceeds 2*N_REQ-1.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         sum = {1'b0, last} + (ID_W + 1)'(k);
         if (sum >= N_REQ_W) sum = sum - N_REQ_W;
         idx = sum[ID_W-1:0];
         if (!found && req_valid[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = idx;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) sel_data = req_data[64*i +: 64];
      end
   end

   assign req_ready = rst ? '0 : (grant & {N_REQ{s0_en}});
   assign xfer      = found & s0_en & !rst;

   clz64 u_clz (
      .a (s0_data),
      .y (clz_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last     <= ID_W'(N_REQ - 1);
         s0_valid <= 1'b0;
         s0_id    <= '0;
         s0_data  <= '0;
      end else if (s0_en) begin
         s0_valid <= xfer;
         if (xfer) begin
            last    <= grant_id;
            s0_id   <= grant_id;
            s0_data <= sel_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         s1_clz   <= '0;
         s1_zero  <= 1'b0;
      end else if (s1_en) begin
         s1_valid <= s0_valid;
         if (s0_valid) begin
            s1_id <= s0_id;
            // clz64 reports 0 for an all-zero word, so that case is patched here.
            if (s0_data == 64'd0) begin
               s1_clz  <= 7'd64;
               s1_zero <= 1'b1;
            end else begin
               s1_clz  <= {1'b0, clz_y};
               s1_zero <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_count <= '0;
      end else if (s1_valid && out_ready) begin
         res_count <= res_count + 16'd1;
      end
   end

   assign out_valid = s1_valid;
   assign out_id    = s1_id;
   assign out_clz   = s1_clz;
   assign out_zero  = s1_zero;
endmodule

// File: tb/tb_clz_share_arb.sv
// tb/tb_clz_share_arb.sv - directed scoreboard bench for clz_share_arb
// Expected results are queued at each accepted transfer and popped at each output handshake.

module tb_clz_share_arb;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [64*N-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic            out_ready;
   logic [1:0]      out_id;
   logic [6:0]      out_clz;
   logic            out_zero;
   logic [15:0]     res_count;

   clz_share_arb #(.N_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_id    (out_id),
      .out_clz   (out_clz),
      .out_zero  (out_zero),
      .res_count (res_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] id;
      logic [6:0] clz;
      logic       zero;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] words[N][32];
   int          wr_n[N];
   int          rd_p[N];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] n_out;
   logic [N-1:0] s_acc;
   logic [N-1:0] s_req_ready;
   logic        s_out_valid;
   logic        s_out_hs;
   int          acc_total;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] model_clz(input logic [63:0] w);
      for (int b = 63; b >= 0; b--) begin
         if (w[b]) return 7'(63 - b);
      end
      return 7'd64;
   endfunction

   task automatic push_word(input int id, input logic [63:0] w);
      words[id][wr_n[id]] = w;
      wr_n[id]++;
   endtask

   task automatic refresh();
      for (int i = 0; i < N; i++) begin
         if (rd_p[i] < wr_n[i]) begin
            req_valid[i]        = 1'b1;
            req_data[64*i +: 64] = words[i][rd_p[i]];
         end else begin
            req_valid[i]        = 1'b0;
            req_data[64*i +: 64] = '0;
         end
      end
   endtask

   // One cycle: sample at the falling edge, then advance requesters after the rising edge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      s_acc       = req_valid & req_ready;
      s_req_ready = req_ready;
      s_out_valid = out_valid;
      s_out_hs    = out_valid & out_ready;
      chk("res_count", 64'(res_count), 64'(n_out));
      for (int i = 0; i < N; i++) begin
         if (s_acc[i]) begin
            e.id   = 2'(i);
            e.clz  = model_clz(words[i][rd_p[i]]);
            e.zero = (words[i][rd_p[i]] == 64'd0);
            sb.push_back(e);
         end
      end
      if (s_out_hs) begin
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_id", 64'(out_id), 64'(e.id));
            chk("out_clz", 64'(out_clz), 64'(e.clz));
            chk("out_zero", 64'(out_zero), 64'(e.zero));
         end
         n_out++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (s_acc[i]) rd_p[i]++;
      end
      refresh();
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      for (int k = 0; k < 300; k++) begin
         done = (sb.size() == 0);
         for (int i = 0; i < N; i++) begin
            if (rd_p[i] != wr_n[i]) done = 1'b0;
         end
         if (done) break;
         step();
      end
      chk("drain_done", 64'(done), 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sb.delete();
      n_out = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         wr_n[i] = 0;
         rd_p[i] = 0;
      end
      n_out     = '0;
      out_ready = 1'b1;
      req_valid = '1;
      req_data  = '0;
      rst       = 1'b1;

      // Reset state, with requests pending to show req_ready gated by rst.
      @(posedge clk);
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_id", 64'(out_id), 64'd0);
      chk("rst_out_clz", 64'(out_clz), 64'd0);
      chk("rst_out_zero", 64'(out_zero), 64'd0);
      chk("rst_res_count", 64'(res_count), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      refresh();

      // Single request on requester 2, two-cycle latency.
      push_word(2, 64'h0000_0001_0000_0000);
      refresh();
      step();
      chk("single_acc", 64'(s_acc), 64'b0100);
      step();
      chk("single_t1_valid", 64'(s_out_valid), 64'd0);
      step();
      chk("single_t2_valid", 64'(s_out_valid), 64'd1);
      drain();

      // Boundary words through requester 0.
      push_word(0, 64'h8000_0000_0000_0000);
      push_word(0, 64'h1);
      push_word(0, 64'h0);
      refresh();
      drain();

      // Fairness: all requesters valid with two words each.
      do_reset();
      for (int i = 0; i < N; i++) begin
         push_word(i, 64'h1 << (i * 16 + 3));
         push_word(i, 64'hFFFF << (i * 8));
      end
      refresh();
      for (int k = 0; k < 10; k++) begin
         step();
         chk("fair_grant", 64'(s_acc), (k < 8) ? 64'(1 << (k % N)) : 64'd0);
         chk("fair_out_hs", 64'(s_out_hs), (k >= 2) ? 64'd1 : 64'd0);
      end
      step();
      chk("fair_res_count8", 64'(res_count), 64'd8);

      // Backpressure: stall output five cycles under full load.
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < 4; j++) begin
            push_word(i, {$urandom(), $urandom()} >> $urandom_range(0, 64));
         end
      end
      refresh();
      acc_total = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         acc_total += $countones(s_acc);
      end
      chk("bp_accepted", 64'(acc_total), 64'd2);
      chk("bp_req_ready", 64'(s_req_ready), 64'd0);
      chk("bp_out_valid", 64'(s_out_valid), 64'd1);
      out_ready = 1'b1;
      drain();

      // Reset with both stages full.
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < 4; j++) begin
            push_word(i, {$urandom(), $urandom()});
         end
      end
      refresh();
      step();
      step();
      step();
      chk("mid_full", 64'(s_out_valid), 64'd1);
      rst = 1'b1;
      sb.delete();
      n_out = '0;
      #1;
      chk("mid_out_valid", 64'(out_valid), 64'd0);
      chk("mid_res_count", 64'(res_count), 64'd0);
      chk("mid_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      chk("mid_first_grant", 64'(s_acc), 64'b0001);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
